// File: rtl/tmr_scrub_ctrl.sv
// tmr_scrub_ctrl: sequences host reads/writes and background scrub reads onto a TMR memory
// Ports:
//   clk, rst                     rising-edge clock, synchronous active-high reset
//   host_req/host_we/host_addr/host_wdata  host request, held until host_gnt
//   host_gnt                     one-cycle accept pulse; operands captured on that cycle
//   host_rvalid, host_rdata      voted read data, two cycles after host_gnt
//   mem_enable/mem_we/mem_addr/mem_wdata   TMR memory controls
//   mem_rdata, mem_mismatch      registered voted data and replica-mismatch flag
//   scrub_busy                   scrub access in progress
//   corr_cnt                     saturating count of corrected reads
// Build option: define TMR_SCRUB_EN to include the periodic background scrubber
module tmr_scrub_ctrl #(
    parameter int SCRUB_PERIOD = 1024,
    parameter int STARVE_MAX   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        host_req,
    input  logic        host_we,
    input  logic [7:0]  host_addr,
    input  logic [7:0]  host_wdata,
    output logic        host_gnt,
    output logic        host_rvalid,
    output logic [7:0]  host_rdata,
    output logic        mem_enable,
    output logic        mem_we,
    output logic [7:0]  mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_mismatch,
    output logic        scrub_busy,
    output logic [15:0] corr_cnt
);
    if (SCRUB_PERIOD < 2 || SCRUB_PERIOD > 65535) begin : g_bad_period
        $error("SCRUB_PERIOD must be within 2..65535");
    end
    if (STARVE_MAX < 0 || STARVE_MAX > 65535) begin : g_bad_starve
        $error("STARVE_MAX must be within 0..65535");
    end

    typedef enum logic [2:0] {
        IDLE, RD_ISSUE, RD_CHECK, WR
`ifdef TMR_SCRUB_EN
        , SC_ISSUE, SC_CHECK
`endif
    } state_t;

    state_t      r_state, w_next;
    logic [7:0]  r_addr, r_wdata;
    logic [15:0] r_corr;
    logic        w_host_go, w_chk;

`ifdef TMR_SCRUB_EN
    logic [15:0] r_timer, r_starve;
    logic [7:0]  r_sptr;
    logic        r_pend, w_expire, w_starved, w_sc_go;
    assign w_expire  = r_timer == 16'(SCRUB_PERIOD - 1);
    // the host loses arbitration only once it has starved a pending scrub long enough
    assign w_starved = r_pend && r_starve == 16'(STARVE_MAX);
    assign w_host_go = r_state == IDLE && host_req && !w_starved;
    assign w_sc_go   = r_state == IDLE && r_pend && !w_host_go;
    assign w_chk     = r_state == RD_CHECK || r_state == SC_CHECK;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timer  <= '0;
            r_starve <= '0;
            r_sptr   <= '0;
            r_pend   <= 1'b0;
        end else begin
            r_timer <= w_expire ? '0 : r_timer + 16'd1;
            // a scrub grant clears the pending flag even if the timer expires on the same
            // cycle: that expiry lands while a scrub is already pending and is dropped
            r_pend  <= w_sc_go ? 1'b0 : (r_pend | w_expire);
            if (w_sc_go)
                r_starve <= '0;
            else if (w_host_go && r_pend)
                r_starve <= r_starve + 16'd1;
            if (r_state == SC_CHECK)
                r_sptr <= r_sptr + 8'd1;
        end
    end
`else
    assign w_host_go = r_state == IDLE && host_req;
    assign w_chk     = r_state == RD_CHECK;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
`ifdef TMR_SCRUB_EN
            IDLE:     w_next = w_host_go ? (host_we ? WR : RD_ISSUE) : (w_sc_go ? SC_ISSUE : IDLE);
            SC_ISSUE: w_next = SC_CHECK;
            SC_CHECK: w_next = IDLE;
`else
            IDLE:     w_next = w_host_go ? (host_we ? WR : RD_ISSUE) : IDLE;
`endif
            RD_ISSUE: w_next = RD_CHECK;
            RD_CHECK: w_next = IDLE;
            WR:       w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    // outputs are forced low during reset so an access cut short by rst never reports data
    always_comb begin
        host_gnt    = 1'b0;
        host_rvalid = 1'b0;
        host_rdata  = 8'h00;
        mem_enable  = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = 8'h00;
        mem_wdata   = 8'h00;
        scrub_busy  = 1'b0;
        if (!rst) begin
            host_gnt = w_host_go;
            case (r_state)
                RD_ISSUE: begin
                    mem_enable = 1'b1;
                    mem_addr   = r_addr;
                end
                // address held so the memory can write the voted value back
                RD_CHECK: begin
                    mem_enable  = 1'b1;
                    mem_addr    = r_addr;
                    host_rvalid = 1'b1;
                    host_rdata  = mem_rdata;
                end
                WR: begin
                    mem_enable = 1'b1;
                    mem_we     = 1'b1;
                    mem_addr   = r_addr;
                    mem_wdata  = r_wdata;
                end
`ifdef TMR_SCRUB_EN
                SC_ISSUE, SC_CHECK: begin
                    mem_enable = 1'b1;
                    mem_addr   = r_sptr;
                    scrub_busy = 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_corr  <= '0;
        end else begin
            if (w_host_go) begin
                r_addr  <= host_addr;
                r_wdata <= host_wdata;
            end
            if (w_chk && mem_mismatch && r_corr != 16'hffff)
                r_corr <= r_corr + 16'd1;
        end
    end

    assign corr_cnt = r_corr;
endmodule

// File: tb/tb_tmr_scrub_ctrl.sv
// tb_tmr_scrub_ctrl: directed and random host traffic against a behavioural TMR memory and scrub-policy model
module tb_tmr_scrub_ctrl;
    localparam int PERIOD = 8;
    localparam int SMAX   = 4;

    logic        clk = 1'b0, rst = 1'b1;
    logic        host_req = 1'b0, host_we = 1'b0;
    logic [7:0]  host_addr = 8'h00, host_wdata = 8'h00;
    logic        host_gnt, host_rvalid, mem_enable, mem_we, scrub_busy, mem_mismatch;
    logic [7:0]  host_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [15:0] corr_cnt;

    logic        mem_clr = 1'b1, inj_en = 1'b0;
    logic [1:0]  inj_rep = 2'd0;
    logic [7:0]  inj_addr = 8'h00, inj_val = 8'h00;
    logic [7:0]  rep [0:2][0:255];
    logic [7:0]  ref_mem [0:255];

    int n_vec = 0, n_fail = 0, exp_corr = 0;
    bit idle_chk = 1'b0, starve_chk = 1'b0;

    always #5 clk = ~clk;

    tmr_scrub_ctrl #(.SCRUB_PERIOD(PERIOD), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .mem_enable(mem_enable), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_mismatch(mem_mismatch),
        .scrub_busy(scrub_busy), .corr_cnt(corr_cnt)
    );

    function automatic logic [7:0] vote(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // TMR memory: registered voted read, mismatch flag, and write-back of the vote on every read
    always @(posedge clk) begin
        mem_mismatch <= 1'b0;
        if (mem_clr) begin
            mem_rdata <= 8'h00;
            for (int i = 0; i < 256; i++)
                for (int r = 0; r < 3; r++)
                    rep[r][i] <= 8'h00;
        end else if (mem_enable && mem_we) begin
            for (int r = 0; r < 3; r++)
                rep[r][mem_addr] <= mem_wdata;
        end else if (mem_enable) begin
            mem_rdata    <= vote(rep[0][mem_addr], rep[1][mem_addr], rep[2][mem_addr]);
            mem_mismatch <= rep[0][mem_addr] !== rep[1][mem_addr] || rep[1][mem_addr] !== rep[2][mem_addr];
            for (int r = 0; r < 3; r++)
                rep[r][mem_addr] <= vote(rep[0][mem_addr], rep[1][mem_addr], rep[2][mem_addr]);
        end
        if (inj_en)
            rep[inj_rep][inj_addr] <= inj_val;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // called just after a rising edge; returns at the sampling point of the grant cycle
    task automatic req_gnt(input logic we, input logic [7:0] a, input logic [7:0] d, output int w);
        host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
        w = 0;
        @(negedge clk);
        while (host_gnt !== 1'b1 && w < 30) begin
            @(negedge clk);
            w++;
        end
        chk("gnt_wait", host_gnt, 1);
    endtask

    // called just after a rising edge; returns just after a rising edge with the DUT idle
    task automatic host_op(input logic we, input logic [7:0] a, input logic [7:0] d, output int w);
        req_gnt(we, a, d, w);
        @(posedge clk); #1;
        host_req = 1'b0; host_we = 1'($urandom); host_addr = 8'($urandom); host_wdata = 8'($urandom);
        @(negedge clk);
        chk(we ? "wr_en" : "rd_en", mem_enable, 1);
        chk("mem_we", mem_we, we);
        chk("mem_addr", mem_addr, a);
        if (we) begin
            chk("mem_wdata", mem_wdata, d);
            ref_mem[a] = d;
        end else begin
            chk("rvalid_early", host_rvalid, 0);
            @(posedge clk); #1;
            @(negedge clk);
            chk("rd_hold_addr", mem_addr, a);
            chk("rvalid", host_rvalid, 1);
            chk("rdata", host_rdata, ref_mem[a]);
        end
        @(posedge clk); #1;
    endtask

    task automatic inject(input logic [1:0] r, input logic [7:0] a, input logic [7:0] v);
        inj_en = 1'b1; inj_rep = r; inj_addr = a; inj_val = v;
        @(posedge clk); #1;
        inj_en = 1'b0;
    endtask

    // scrub-policy model: timer expiries every PERIOD cycles since reset set a pending flag,
    // a scrub start clears it, and host grants made while it is set are counted
    int         k = 0, last_rise = -1, hp = 0, n_sc = 0;
    bit         p = 1'b0, p_prev = 1'b0, prev_busy = 1'b0;
    logic [7:0] exp_ptr = 8'h00;
    always @(negedge clk) begin
`ifdef TMR_SCRUB_EN
        if (rst) begin
            k = 0; p = 1'b0; hp = 0; exp_ptr = 8'h00; prev_busy = 1'b0; last_rise = -1;
        end else begin
            p_prev = p;
            if (k > 0)
                p = (scrub_busy && !prev_busy) ? 1'b0 : (p | ((k - 1) % PERIOD == PERIOD - 1));
            if (scrub_busy && !prev_busy) begin
                chk("scrub_addr", mem_addr, exp_ptr);
                chk("scrub_pending", p_prev, 1);
                chk("scrub_rd", {mem_enable, mem_we}, 2'b10);
                if (starve_chk)
                    chk("starve_grants", hp, SMAX);
                if (idle_chk && last_rise >= 0)
                    chk("scrub_interval", k - last_rise, PERIOD);
                exp_ptr++;
                hp = 0;
                n_sc++;
                last_rise = k;
            end
            if (!scrub_busy && prev_busy) begin
                if (idle_chk)
                    chk("scrub_len", k - last_rise, 2);
                if (starve_chk)
                    chk("host_resume", host_gnt, 1);
            end
            if (host_gnt && p)
                hp++;
            prev_busy = scrub_busy;
            k++;
        end
`else
        chk("no_scrub", scrub_busy, 0);
`endif
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int         w, n0;
        logic [7:0] a, d;
        for (int i = 0; i < 256; i++)
            ref_mem[i] = 8'h00;
        host_req = 1'b1;
        repeat (3) @(posedge clk);
        #1 mem_clr = 1'b0;
        @(negedge clk);
        chk("rst_gnt", host_gnt, 0);
        chk("rst_rvalid", host_rvalid, 0);
        chk("rst_en", mem_enable, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_busy", scrub_busy, 0);
        chk("rst_rdata", host_rdata, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_corr", corr_cnt, 0);
        @(posedge clk); #1;
        rst = 1'b0; host_req = 1'b0;

        host_op(1'b1, 8'h10, 8'hA5, w);
        host_op(1'b0, 8'h10, 8'h00, w);
        chk("read_a5", ref_mem[8'h10], 8'hA5);

        inject(2'd2, 8'h10, 8'h00);
        host_op(1'b0, 8'h10, 8'h00, w);
        exp_corr = 1;
        chk("corr_one", corr_cnt, exp_corr);
        chk("replica_fixed", rep[2][8'h10], 8'hA5);

        req_gnt(1'b0, 8'h10, 8'h00, w);
        @(posedge clk); #1;
        host_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_rvalid", host_rvalid, 0);
        chk("abort_gnt", host_gnt, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("post_rst_en", mem_enable, 0);
        chk("post_rst_rvalid", host_rvalid, 0);
        chk("post_rst_addr", mem_addr, 0);
        chk("post_rst_rdata", host_rdata, 0);
        chk("post_rst_corr", corr_cnt, 0);
        exp_corr = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        host_op(1'b0, 8'h10, 8'h00, w);
        chk("first_gnt_after_rst", w, 0);

        repeat (40) begin
            a = 8'($urandom_range(0, 15));
            d = 8'($urandom);
            host_op(1'($urandom_range(0, 1)), a, d, w);
        end
        chk("corr_after_random", corr_cnt, exp_corr);

`ifndef TMR_SCRUB_EN
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h10;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            chk("b2b_gnt", host_gnt, (i % 3) == 0);
            chk("b2b_rvalid", host_rvalid, (i % 3) == 2);
            if (i % 3 == 2)
                chk("b2b_rdata", host_rdata, ref_mem[8'h10]);
        end
        @(posedge clk); #1;
        host_req = 1'b0;
`else
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; exp_corr = 0;
        starve_chk = 1'b1; n0 = n_sc;
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h10;
        repeat (80) @(posedge clk);
        #1 host_req = 1'b0; starve_chk = 1'b0;
        chk("starve_scrubs", (n_sc - n0) >= 3, 1);

        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        inject(2'd1, 8'h05, ~ref_mem[8'h05]);
        idle_chk = 1'b1; n0 = n_sc;
        repeat (PERIOD * 258) @(posedge clk);
        #1 idle_chk = 1'b0;
        chk("idle_scrubs", (n_sc - n0) >= 257, 1);
        exp_corr = 1;
        chk("scrub_corr", corr_cnt, exp_corr);
        chk("scrub_fixed", rep[1][8'h05], ref_mem[8'h05]);
`endif

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
